// File: rtl/wu_fetch_engine.sv
// wu_fetch_engine: streams WU memory words into a credit-limited prefetch FIFO for a downstream consumer.
module wu_fetch_engine #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 1,
    parameter int EOW_BIT    = DATA_W - 1
) (
    input  logic              clk,
    input  logic              reset_poweron,
    input  logic              mcntl__wuf__enable,
    input  logic [ADDR_W-1:0] mcntl__wuf__start_addr,
    input  logic [ADDR_W-1:0] mcntl__wuf__num_words,
    input  logic              xxx__wuf__stall,
    output logic              wuf__wum__read,
    output logic [ADDR_W-1:0] wuf__wum__addr,
    input  logic [DATA_W-1:0] wum__wuf__data,
    output logic              wuf__xxx__valid,
    output logic [DATA_W-1:0] wuf__xxx__data,
    input  logic              xxx__wuf__ready,
    output logic              wuf__mcntl__busy,
    output logic              wuf__mcntl__done
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   next_addr;
    logic [ADDR_W-1:0]   remaining;
    logic                marker;
    logic [RD_LAT-1:0]   pipe;
    logic [CW-1:0]       outstanding;
    logic [CW-1:0]       occ;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic                issue;
    logic                arrive;
    logic                wr;
    logic                pop;
    logic                eow;
    logic                credit;
    logic                limit_ok;

    // A return is expected RD_LAT cycles after each registered read strobe.
    assign arrive   = pipe[RD_LAT-1];
    // Outstanding reads plus buffered words may never exceed the buffer size.
    assign credit   = (outstanding + occ) < CW'(FIFO_DEPTH);
    // In marker mode everything returning after the marker (i.e. in DRAIN) is dropped.
    assign wr       = arrive && (state == FETCH || (state == DRAIN && !marker));
    assign eow      = wr && marker && wum__wuf__data[EOW_BIT];
    assign limit_ok = marker ? !eow : remaining != '0;
    assign issue    = state == FETCH && !xxx__wuf__stall && credit && limit_ok;
    assign pop      = wuf__xxx__valid && xxx__wuf__ready;

    assign wuf__xxx__valid  = occ != '0;
    assign wuf__xxx__data   = wuf__xxx__valid ? mem[rd_ptr] : '0;
    assign wuf__mcntl__done = state == DRAIN && outstanding == '0 && occ == '0;
    assign wuf__mcntl__busy = state != IDLE && !wuf__mcntl__done;

    // Next-state: start on enable, stop issuing at the count limit or marker, finish once drained.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (mcntl__wuf__enable) state_n = FETCH;
            FETCH:   if (marker ? eow : (issue && remaining == ADDR_W'(1))) state_n = DRAIN;
            DRAIN:   if (wuf__mcntl__done) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Control state, read issue, address generation and in-flight tracking.
    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            state          <= IDLE;
            next_addr      <= '0;
            remaining      <= '0;
            marker         <= 1'b0;
            wuf__wum__read <= 1'b0;
            wuf__wum__addr <= '0;
            pipe           <= '0;
            outstanding    <= '0;
        end else begin
            state          <= state_n;
            wuf__wum__read <= issue;
            pipe           <= (pipe << 1) | RD_LAT'(wuf__wum__read);
            outstanding    <= outstanding + CW'(issue) - CW'(arrive);
            if (state == IDLE && mcntl__wuf__enable) begin
                next_addr <= mcntl__wuf__start_addr;
                remaining <= mcntl__wuf__num_words;
                marker    <= mcntl__wuf__num_words == '0;
            end
            if (issue) begin
                wuf__wum__addr <= next_addr;
                next_addr      <= next_addr + ADDR_W'(1);
                remaining      <= remaining - ADDR_W'(1);
            end
        end
    end

    // Prefetch FIFO pointers and occupancy; write and pop may coincide.
    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            occ <= occ + CW'(wr) - CW'(pop);
        end
    end

    // FIFO storage; contents are only visible while valid, so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= wum__wuf__data;
    end
endmodule

// File: doc/wu_fetch_engine.md
WU_FETCH_ENGINE -- requirements
Module: wu_fetch_engine

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, WU memory address width.
REQ-002 SHALL have parameter DATA_W, default 64, WU memory word width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, prefetch buffer entries; power of 2, >= RD_LAT+1.
REQ-004 SHALL have parameter RD_LAT, default 1, WU memory read latency in cycles (1..4).
REQ-005 SHALL have parameter EOW_BIT, default DATA_W-1, bit index of end-of-WU marker.
REQ-006 SHALL have port clk  in  1  sole clock, all flops on posedge.
REQ-007 SHALL have port reset_poweron  in  1  reset; asynchronous, active-high.
REQ-008 SHALL have port mcntl__wuf__enable  in  1  start pulse.
REQ-009 SHALL have port mcntl__wuf__start_addr  in  ADDR_W  first WU address.
REQ-010 SHALL have port mcntl__wuf__num_words  in  ADDR_W  word count; 0 selects end-marker mode.
REQ-011 SHALL have port xxx__wuf__stall  in  1  inhibits new read issue.
REQ-012 SHALL have port wuf__wum__read  out  1  WU memory read strobe, registered.
REQ-013 SHALL have port wuf__wum__addr  out  ADDR_W  WU memory read address, registered.
REQ-014 SHALL have port wum__wuf__data  in  DATA_W  read data, valid RD_LAT cycles after the read cycle.
REQ-015 SHALL have port wuf__xxx__valid  out  1  output word valid.
REQ-016 SHALL have port wuf__xxx__data  out  DATA_W  output word (FIFO head).
REQ-017 SHALL have port xxx__wuf__ready  in  1  consumer accepts word when valid&ready.
REQ-018 SHALL have port wuf__mcntl__busy  out  1  high from start until done.
REQ-019 SHALL have port wuf__mcntl__done  out  1  one-cycle completion pulse.

Function
REQ-020 SHALL implement FSM IDLE, FETCH, DRAIN.
REQ-021 IDLE: enable sampled high at edge T -> latch start_addr/num_words, enter FETCH; busy high from T+1.
REQ-022 enable while not IDLE SHALL be ignored.
REQ-023 FETCH: read issued in a cycle iff !stall, credits available, and issue limit not reached; first read no earlier than cycle T+1 at start_addr.
REQ-024 Credits: outstanding reads + FIFO occupancy SHALL never exceed FIFO_DEPTH; no read issued otherwise.
REQ-025 Each issued read SHALL increment address by 1, wrapping modulo 2^ADDR_W (0xFFFF -> 0x0000 at ADDR_W=16).
REQ-026 Count mode (num_words != 0): exactly num_words reads issued, then FETCH -> DRAIN.
REQ-027 Marker mode (num_words == 0): reads continue until a returned word with bit EOW_BIT=1 is written to FIFO; then FETCH -> DRAIN.
REQ-028 Marker mode: words returning after the marker word SHALL be discarded, not written to FIFO.
REQ-029 Returned data SHALL be written to FIFO on arrival, independent of stall and ready; credits guarantee no overflow.
REQ-030 FIFO SHALL preserve order; valid high the cycle after first write; data stable while valid & !ready.
REQ-031 Simultaneous FIFO write and pop when full or empty SHALL both complete without loss or duplicate.
REQ-032 DRAIN: when outstanding=0 and FIFO empty -> done pulse one cycle, busy low same cycle, return IDLE.
REQ-033 Stall SHALL affect issue only; outstanding reads still complete.
REQ-034 wuf__wum__read SHALL be low whenever no read is issued; addr holds last issued value.

Reset
REQ-035 reset_poweron high SHALL asynchronously force FSM IDLE, read 0, addr 0, valid 0, data 0, busy 0, done 0, FIFO empty, outstanding 0.
REQ-036 Reset mid-operation: in-flight returns SHALL be discarded (latency tracker cleared); next enable starts cleanly.

Verification
REQ-037 start=0x0010, num=3, ready=1, no stall -> reads at 0x10,0x11,0x12 in consecutive cycles, 3 words out in order, one done pulse, busy low after.
REQ-038 num=8, ready=0, FIFO_DEPTH=4 -> exactly 4 reads issued then read held low, valid high, data stable; ready=1 -> remaining 4 fetched, 8 words total in order.
REQ-039 num=0, word at offset 2 has EOW_BIT set -> words 0..2 delivered, later returns dropped, done pulses.
REQ-040 ADDR_W=16, start=0xFFFE, num=4 -> addresses 0xFFFE,0xFFFF,0x0000,0x0001.
REQ-041 stall high 3 cycles mid-run -> no reads in those cycles, in-flight data still enqueued, no word lost.
REQ-042 reset asserted with 2 reads outstanding -> all outputs 0 immediately, returning data ignored; enable after release -> correct fetch from new start_addr.
